pc_gen: RTL and testbench

Parametrised program-counter generator; the successor to the single-register `pc` block. It owns the fetch address and chooses the next PC each cycle: sequential step, branch/jump redirect, or trap vector. It adds stall, halt/resume and a fetch valid/ready handshake, and it checks redirect targets for misalignment. It sits between the execute/trap logic and the instruction-memory port of the single-cycle core.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_align_chk.sv | 18 +
 rtl/pc_gen.sv | 117 +++++++++++
 tb/tb_pc_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
// PC_COMPRESSED_EN selects 16-bit instruction support (2-byte steps and alignment).
package pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  localparam int PC_STEP_32 = 4;
  localparam int PC_STEP_16 = 2;

  // Low address bits that must be zero for a legal instruction address.
`ifdef PC_COMPRESSED_EN
  localparam logic [1:0] PC_ALIGN_MASK = 2'b01;
`else
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;
`endif

endpackage

// File: rtl/pc_align_chk.sv
// Combinational instruction-address alignment checker; also yields the address
// with the offending low bits cleared (used for trap vectors).
module pc_align_chk
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] addr,
  output logic            aligned,
  output logic [XLEN-1:0] aligned_addr
);

  always_comb begin
    aligned      = ((addr[1:0] & PC_ALIGN_MASK) == 2'b00);
    aligned_addr = {addr[XLEN-1:2], addr[1:0] & ~PC_ALIGN_MASK};
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential step, redirect, trap, stall and halt/resume
// with a fetch valid/ready handshake. PC_COMPRESSED_EN enables 2-byte stepping.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            fetch_ready,
  input  logic            instr_len16,
  output logic [XLEN-1:0] curr_pc,
  output logic [XLEN-1:0] pc_plus_step,
  output logic            fetch_valid,
  output logic            halted,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
  output pc_state_e       state_dbg
);

  // Fetch handshake: a request is offered while fetch_valid is high and is
  // consumed on any rising edge where fetch_ready is also high and stall is low.
  // curr_pc is held while fetch_valid && !fetch_ready, except on redirect/trap.

  pc_state_e       state, state_next;
  logic [XLEN-1:0] pc_next;
  logic            misaligned_next;
  logic [XLEN-1:0] bad_addr_next;
  logic [XLEN-1:0] step;

  logic            redir_aligned;
  logic [XLEN-1:0] redir_unused_addr;
  logic            trap_unused_aligned;
  logic [XLEN-1:0] trap_vector;

`ifdef PC_COMPRESSED_EN
  assign step = instr_len16 ? XLEN'(PC_STEP_16) : XLEN'(PC_STEP_32);
`else
  logic unused_instr_len16;
  assign unused_instr_len16 = instr_len16;
  assign step = XLEN'(PC_STEP_32);
`endif

  pc_align_chk #(.XLEN(XLEN)) u_redir_chk (
    .addr         (redirect_target),
    .aligned      (redir_aligned),
    .aligned_addr (redir_unused_addr)
  );

  pc_align_chk #(.XLEN(XLEN)) u_trap_chk (
    .addr         (trap_target),
    .aligned      (trap_unused_aligned),
    .aligned_addr (trap_vector)
  );

  assign pc_plus_step = curr_pc + step;
  assign fetch_valid  = (state == PC_RUN);
  assign halted       = (state == PC_HALT);
  assign state_dbg    = state;

  // Priority: trap > redirect (RUN only) > halt > stall > sequential.
  always_comb begin
    state_next      = state;
    pc_next         = curr_pc;
    misaligned_next = 1'b0;
    bad_addr_next   = bad_addr;
    if (trap_valid) begin
      state_next = PC_RUN;
      pc_next    = trap_vector;
    end else if (redirect_valid && state == PC_RUN) begin
      if (redir_aligned) begin
        pc_next = redirect_target;
      end else begin
        misaligned_next = 1'b1;
        bad_addr_next   = redirect_target;
      end
    end else begin
      case (state)
        PC_BOOT: state_next = PC_RUN;
        PC_RUN: begin
          if (halt_req) begin
            state_next = PC_HALT;
          end else if (fetch_ready && !stall) begin
            pc_next = pc_plus_step;
          end
        end
        PC_HALT: begin
          if (resume_req) state_next = PC_RUN;
        end
        default: state_next = PC_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PC_BOOT;
      curr_pc    <= RESET_VECTOR;
      misaligned <= 1'b0;
      bad_addr   <= '0;
    end else begin
      state      <= state_next;
      curr_pc    <= pc_next;
      misaligned <= misaligned_next;
      bad_addr   <= bad_addr_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (default build; PC_COMPRESSED_EN adds 16-bit cases).
module tb_pc_gen;
  import pc_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            halt_req;
  logic            resume_req;
  logic            fetch_ready;
  logic            instr_len16;
  logic [XLEN-1:0] curr_pc;
  logic [XLEN-1:0] pc_plus_step;
  logic            fetch_valid;
  logic            halted;
  logic            misaligned;
  logic [XLEN-1:0] bad_addr;
  pc_state_e       state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .halt_req        (halt_req),
    .resume_req      (resume_req),
    .fetch_ready     (fetch_ready),
    .instr_len16     (instr_len16),
    .curr_pc         (curr_pc),
    .pc_plus_step    (pc_plus_step),
    .fetch_valid     (fetch_valid),
    .halted          (halted),
    .misaligned      (misaligned),
    .bad_addr        (bad_addr),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; redirect_valid = 0; redirect_target = '0;
    trap_valid = 0; trap_target = '0; halt_req = 0; resume_req = 0;
    fetch_ready = 0; instr_len16 = 0;
  endtask

  task automatic chk_pc(input string name, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (curr_pc !== exp) begin
      n_bad++;
      $display("FAIL %s: curr_pc=%h expected=%h", name, curr_pc, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic fv, input logic h, input logic m);
    n_cmp++;
    if ({fetch_valid, halted, misaligned} !== {fv, h, m}) begin
      n_bad++;
      $display("FAIL %s: fv/halted/mis=%b%b%b expected=%b%b%b", name,
               fetch_valid, halted, misaligned, fv, h, m);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; redirect_valid = 1; redirect_target = 32'hDEADBEEF;
    tick(); tick();
    chk_pc("reset_pc", 32'h0);
    chk_flags("reset_flags", 0, 0, 0);
    n_cmp++;
    if (bad_addr !== 32'h0 || state_dbg !== PC_BOOT) begin
      n_bad++;
      $display("FAIL reset_state: bad_addr=%h state=%0d expected 0/BOOT", bad_addr, state_dbg);
    end
    reset = 0;
    #2;
    chk_flags("boot_after_release", 0, 0, 0);
    tick();
    chk_pc("first_fetch_pc", 32'h0);
    chk_flags("first_fetch_flags", 1, 0, 0);
    redirect_valid = 0;
  endtask

  task automatic test_sequential();
    logic [XLEN-1:0] exp_pc [4];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
    fetch_ready = 1;
    n_cmp++;
    if (pc_plus_step !== 32'h4) begin
      n_bad++;
      $display("FAIL pc_plus_step: got=%h expected=%h", pc_plus_step, 32'h4);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_pc($sformatf("seq_%0d", i), exp_pc[i]);
    end
    fetch_ready = 0;
    tick();
    chk_pc("hold_not_ready", 32'h10);
    chk_flags("hold_not_ready_flags", 1, 0, 0);
    fetch_ready = 1; stall = 1;
    tick();
    chk_pc("hold_stall", 32'h10);
    stall = 0; fetch_ready = 0;
  endtask

  task automatic test_redirect();
    stall = 1; redirect_valid = 1; redirect_target = 32'h100;
    tick();
    chk_pc("redirect_over_stall", 32'h100);
    chk_flags("redirect_flags", 1, 0, 0);
    stall = 0;
`ifdef PC_COMPRESSED_EN
    redirect_target = 32'h103;
`else
    redirect_target = 32'h102;
`endif
    tick();
    chk_pc("misaligned_hold", 32'h100);
    chk_flags("misaligned_pulse", 1, 0, 1);
    n_cmp++;
    if (bad_addr !== redirect_target) begin
      n_bad++;
      $display("FAIL bad_addr: got=%h expected=%h", bad_addr, redirect_target);
    end
    tick();
    chk_flags("misaligned_back_to_back", 1, 0, 1);
    redirect_valid = 0;
    tick();
    chk_flags("misaligned_clears", 1, 0, 0);
    chk_pc("after_misaligned_pc", 32'h100);
  endtask

  task automatic test_trap();
    trap_valid = 1; trap_target = 32'h8000_0003;
    redirect_valid = 1; redirect_target = 32'h200;
    tick();
`ifdef PC_COMPRESSED_EN
    chk_pc("trap_over_redirect", 32'h8000_0002);
`else
    chk_pc("trap_over_redirect", 32'h8000_0000);
`endif
    chk_flags("trap_flags", 1, 0, 0);
    trap_valid = 0; redirect_valid = 0;
    // realign to a known PC for the halt tests
    trap_valid = 1; trap_target = 32'h8000_0000;
    tick();
    trap_valid = 0;
  endtask

  task automatic test_halt();
    fetch_ready = 1; halt_req = 1;
    tick();
    chk_pc("halt_pc_frozen", 32'h8000_0000);
    chk_flags("halt_flags", 0, 1, 0);
    halt_req = 0; redirect_valid = 1; redirect_target = 32'h300;
    tick();
    chk_pc("halt_redirect_ignored", 32'h8000_0000);
    chk_flags("halt_redirect_flags", 0, 1, 0);
    redirect_valid = 0; halt_req = 1; resume_req = 1;
    tick();
    chk_pc("resume_same_pc", 32'h8000_0000);
    chk_flags("resume_wins_in_halt", 1, 0, 0);
    tick();
    chk_flags("halt_wins_in_run", 0, 1, 0);
    chk_pc("halt_wins_pc", 32'h8000_0000);
    halt_req = 0; resume_req = 0; fetch_ready = 0;
    trap_valid = 1; trap_target = 32'h40;
    tick();
    chk_pc("trap_from_halt", 32'h40);
    chk_flags("trap_from_halt_flags", 1, 0, 0);
    trap_valid = 0;
    halt_req = 1;
    tick();
    halt_req = 0; reset = 1;
    tick();
    chk_pc("reset_from_halt_pc", 32'h0);
    chk_flags("reset_from_halt_flags", 0, 0, 0);
    reset = 0;
    tick();
    chk_flags("rerun_after_reset", 1, 0, 0);
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    chk_pc("wrap_setup", 32'hFFFF_FFFC);
    n_cmp++;
    if (pc_plus_step !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_plus_step: got=%h expected=%h", pc_plus_step, 32'h0);
    end
    fetch_ready = 1;
    tick();
    chk_pc("wrap_to_zero", 32'h0);
    chk_flags("wrap_no_flag", 1, 0, 0);
    fetch_ready = 0;
  endtask

`ifdef PC_COMPRESSED_EN
  task automatic test_compressed();
    redirect_valid = 1; redirect_target = 32'h10;
    tick();
    redirect_valid = 0; fetch_ready = 1; instr_len16 = 1;
    tick();
    chk_pc("step16", 32'h12);
    fetch_ready = 0; instr_len16 = 0;
    redirect_valid = 1; redirect_target = 32'h102;
    tick();
    redirect_valid = 0;
    chk_pc("redirect_102_ok", 32'h102);
    chk_flags("redirect_102_flags", 1, 0, 0);
  endtask
`else
  task automatic test_len16_ignored();
    redirect_valid = 1; redirect_target = 32'h10;
    tick();
    redirect_valid = 0; fetch_ready = 1; instr_len16 = 1;
    tick();
    chk_pc("len16_ignored", 32'h14);
    fetch_ready = 0; instr_len16 = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_trap();
    test_halt();
    test_wrap();
`ifdef PC_COMPRESSED_EN
    test_compressed();
`else
    test_len16_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
